// File: rtl/pixel_stream_if.sv
// Output byte stream of pixel_stream: packed pixel pair with sof/eol sideband
// and a valid/ready handshake.
interface pixel_stream_if;
  logic [7:0] out_data;
  logic       out_sof;
  logic       out_eol;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_data, out_sof, out_eol, out_valid, input out_ready);
  modport slave  (input out_data, out_sof, out_eol, out_valid, output out_ready);
endinterface

// File: rtl/pixel_stream.sv
// Sequences the Mandelbrot generator pixel by pixel and packs nibble pairs into a byte FIFO.
// Optional macro PIXEL_STREAM_INVERT_EN stores 15-ctr_in instead of ctr_in.
module pixel_stream #(
  parameter int WIDTH      = 320,
  parameter int HEIGHT     = 240,
  parameter int FIFO_DEPTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           enable,
  input  logic           gen_running,
  input  logic           gen_finished,
  input  logic [3:0]     ctr_in,
  output logic           gen_run,
  output logic           frame_done,
  output logic           busy,
  pixel_stream_if.master out_if
);
  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [YW-1:0] r_pop_line;
  logic [3:0]    r_held;
  logic          r_running_p;
  logic          r_frame_done;
  logic [9:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          w_start;
  logic          w_capture;
  logic          w_push;
  logic          w_pop;
  logic          w_valid;
  logic          w_last_px;
  logic          w_sof;
  logic          w_eol;
  logic [3:0]    w_nib;
  logic [9:0]    w_head;

  function automatic logic [3:0] map_nibble(input logic [3:0] c);
`ifdef PIXEL_STREAM_INVERT_EN
    return 4'd15 - c;
`else
    return c;
`endif
  endfunction

  assign w_nib     = map_nibble(ctr_in);
  assign w_last_px = (r_x == X_LAST) && (r_y == Y_LAST);
  assign w_sof     = (r_x == XW'(1)) && (r_y == '0);
  assign w_eol     = (r_x == X_LAST);
  // Only odd-x captures complete a byte; even-x captures just fill r_held.
  assign w_push    = w_capture && r_x[0];
  assign w_valid   = (r_count != '0);
  assign w_pop     = w_valid && out_if.out_ready;
  assign w_head    = r_mem[r_rd_ptr];

  assign out_if.out_valid = w_valid;
  assign out_if.out_data  = w_valid ? w_head[9:2] : 8'h00;
  assign out_if.out_sof   = w_valid & w_head[1];
  assign out_if.out_eol   = w_valid & w_head[0];
  assign busy             = (r_state != IDLE) || w_valid;
  assign frame_done       = r_frame_done;

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_capture   = 1'b0;
    gen_run     = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable && gen_finished) begin
          w_state_nxt = ISSUE;
          w_start     = 1'b1;
        end
      end
      ISSUE: begin
        // Issuing only with a free slot guarantees the eventual push never hits a full FIFO.
        if (r_count < CW'(FIFO_DEPTH)) begin
          gen_run     = 1'b1;
          w_state_nxt = WAIT_START;
        end
      end
      WAIT_START: begin
        if (gen_running) w_state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (r_running_p && !gen_running) begin
          w_capture   = 1'b1;
          w_state_nxt = w_last_px ? IDLE : ISSUE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_x          <= '0;
      r_y          <= '0;
      r_held       <= '0;
      r_running_p  <= 1'b0;
      r_frame_done <= 1'b0;
      r_pop_line   <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_running_p  <= gen_running;
      r_frame_done <= w_pop && w_head[0] && (r_pop_line == Y_LAST);

      if (w_start) begin
        r_x    <= '0;
        r_y    <= '0;
        r_held <= '0;
      end else if (w_capture) begin
        if (!r_x[0]) r_held <= w_nib;
        if (r_x == X_LAST) begin
          r_x <= '0;
          r_y <= (r_y == Y_LAST) ? '0 : r_y + YW'(1);
        end else begin
          r_x <= r_x + XW'(1);
        end
      end

      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        // Lines are counted on the drain side so frame_done follows the last byte out.
        if (w_head[0]) r_pop_line <= (r_pop_line == Y_LAST) ? '0 : r_pop_line + YW'(1);
      end

      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {w_nib, r_held, w_sof, w_eol};
  end
endmodule

// File: tb/tb_pixel_stream.sv
// Directed/randomized bench for pixel_stream with a generator model and a
// frame-level byte reference derived from the delivered ctr sequence.
module tb_pixel_stream;
  localparam int W   = 4;
  localparam int H   = 2;
  localparam int D   = 2;
  localparam int BPL = W / 2;
  localparam int BPF = W * H / 2;
`ifdef PIXEL_STREAM_INVERT_EN
  localparam logic [7:0] EXP_B0 = 8'hDE, EXP_B1 = 8'hBC, EXP_B2 = 8'h9A, EXP_B3 = 8'h78;
`else
  localparam logic [7:0] EXP_B0 = 8'h21, EXP_B1 = 8'h43, EXP_B2 = 8'h65, EXP_B3 = 8'h87;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       gen_running;
  logic       gen_finished;
  logic [3:0] ctr_in;
  logic       gen_run;
  logic       frame_done;
  logic       busy;

  pixel_stream_if sif ();

  pixel_stream #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .enable(enable), .gen_running(gen_running),
    .gen_finished(gen_finished), .ctr_in(ctr_in), .gen_run(gen_run),
    .frame_done(frame_done), .busy(busy), .out_if(sif)
  );

  always #5 clk = ~clk;

  int         vectors = 0;
  int         miscompares = 0;
  logic [3:0] ctr_q[$];
  logic [3:0] delivered[$];
  logic [7:0] popped[$];
  logic       popped_sof[$];
  logic       popped_eol[$];
  int         pop_idx = 0;
  int         done_count = 0;
  bit         gen_busy = 0;
  bit         ready_rand = 0;
  logic       ready_val = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] ref_nib(input logic [3:0] c);
`ifdef PIXEL_STREAM_INVERT_EN
    return 4'd15 - c;
`else
    return c;
`endif
  endfunction

  // Generator model: answers each gen_run pulse with a running window, ctr held meanwhile.
  initial begin
    gen_running  = 1'b0;
    gen_finished = 1'b1;
    ctr_in       = 4'h0;
    forever begin
      @(negedge clk);
      if (gen_run === 1'b1 && rst === 1'b0) begin
        gen_busy     = 1;
        gen_finished = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        if (ctr_q.size() > 0) ctr_in = ctr_q.pop_front();
        else                  ctr_in = 4'($urandom_range(0, 15));
        delivered.push_back(ctr_in);
        gen_running = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        gen_running  = 1'b0;
        gen_finished = 1'b1;
        gen_busy     = 0;
      end
    end
  end

  initial begin
    sif.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      sif.out_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_val;
    end
  end

  // Monitor: every accepted byte is compared with the pair of ctr values that formed it.
  initial begin
    logic       exp_done;
    logic       prev_stall;
    logic [9:0] prev_head;
    int         k;
    int         f;
    exp_done   = 1'b0;
    prev_stall = 1'b0;
    prev_head  = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        exp_done   = 1'b0;
        prev_stall = 1'b0;
      end else begin
        chk("frame_done", frame_done, exp_done);
        if (frame_done === 1'b1) done_count++;
        if (prev_stall) begin
          chk("hold_valid", sif.out_valid, 1'b1);
          chk("hold_head", {sif.out_data, sif.out_sof, sif.out_eol}, prev_head);
        end
        exp_done = 1'b0;
        if (sif.out_valid === 1'b1 && sif.out_ready === 1'b1) begin
          k = pop_idx;
          f = k % BPF;
          chk("byte_avail", delivered.size() >= 2 * k + 2, 1'b1);
          chk("byte_data", sif.out_data, {ref_nib(delivered[2*k+1]), ref_nib(delivered[2*k])});
          chk("byte_sof", sif.out_sof, f == 0);
          chk("byte_eol", sif.out_eol, (f % BPL) == BPL - 1);
          popped.push_back(sif.out_data);
          popped_sof.push_back(sif.out_sof);
          popped_eol.push_back(sif.out_eol);
          exp_done = (f == BPF - 1);
          pop_idx++;
        end
        prev_stall = (sif.out_valid === 1'b1) && (sif.out_ready === 1'b0);
        prev_head  = {sif.out_data, sif.out_sof, sif.out_eol};
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    delivered.delete();
    popped.delete();
    popped_sof.delete();
    popped_eol.delete();
    ctr_q.delete();
    pop_idx = 0;
  endtask

  task automatic start_frame();
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
  endtask

  task automatic wait_frame(input int want_done);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #2;
      if (done_count >= want_done && busy === 1'b0 && !gen_busy) break;
    end
    chk("frame_count", done_count, want_done);
    chk("frame_busy_low", busy, 1'b0);
  endtask

  initial begin
    int         d0;
    logic [7:0] stall_byte;
    rst    = 1'b1;
    enable = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_gen_run", gen_run, 1'b0);
    chk("rst_valid", sif.out_valid, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_data", sif.out_data, 8'h00);
    chk("rst_sof", sif.out_sof, 1'b0);
    chk("rst_eol", sif.out_eol, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // enable without gen_finished stays in IDLE
    @(negedge clk);
    gen_finished = 1'b0;
    enable       = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      chk("nofin_gen_run", gen_run, 1'b0);
      chk("nofin_busy", busy, 1'b0);
    end
    enable = 1'b0;
    @(negedge clk);
    gen_finished = 1'b1;

    // Fixed ctr 1..8 frame
    clear_logs();
    for (int i = 1; i <= 8; i++) ctr_q.push_back(4'(i));
    ready_val = 1'b1;
    d0 = done_count;
    start_frame();
    wait_frame(d0 + 1);
    chk("fix_nbytes", popped.size(), 4);
    chk("fix_b0", popped[0], EXP_B0);
    chk("fix_b1", popped[1], EXP_B1);
    chk("fix_b2", popped[2], EXP_B2);
    chk("fix_b3", popped[3], EXP_B3);
    chk("fix_sof0", popped_sof[0], 1'b1);
    chk("fix_sof2", popped_sof[2], 1'b0);
    chk("fix_eol0", popped_eol[0], 1'b0);
    chk("fix_eol1", popped_eol[1], 1'b1);
    chk("fix_eol3", popped_eol[3], 1'b1);

    // Backpressure: FIFO fills, issuing stalls, head byte holds
    clear_logs();
    ready_val = 1'b0;
    d0 = done_count;
    start_frame();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #2;
      if (delivered.size() >= 4 && !gen_busy) break;
    end
    repeat (4) @(negedge clk);
    #2;
    chk("bp_delivered", delivered.size(), 4);
    stall_byte = {ref_nib(delivered[1]), ref_nib(delivered[0])};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #2;
      chk("bp_gen_run", gen_run, 1'b0);
      chk("bp_valid", sif.out_valid, 1'b1);
      chk("bp_data", sif.out_data, stall_byte);
      chk("bp_busy", busy, 1'b1);
    end
    chk("bp_no_issue", delivered.size(), 4);
    ready_val = 1'b1;
    wait_frame(d0 + 1);
    chk("bp_nbytes", popped.size(), 4);
    chk("bp_resumed", delivered.size(), 8);

    // Random ctr with random backpressure; exercises push and pop in one cycle
    clear_logs();
    ready_rand = 1;
    for (int fr = 0; fr < 5; fr++) begin
      d0 = done_count;
      start_frame();
      wait_frame(d0 + 1);
    end
    ready_rand = 0;
    ready_val  = 1'b1;
    chk("rand_nbytes", popped.size(), 5 * BPF);

    // Reset during WAIT_DONE of pixel 3
    clear_logs();
    d0 = done_count;
    start_frame();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #2;
      if (delivered.size() == 4 && gen_running === 1'b1) break;
    end
    chk("mid_reached_px3", delivered.size(), 4);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #2;
    chk("mid_valid", sif.out_valid, 1'b0);
    chk("mid_gen_run", gen_run, 1'b0);
    chk("mid_busy", busy, 1'b0);
    for (int i = 0; i < 50; i++) begin
      if (!gen_busy) break;
      @(negedge clk);
    end
    clear_logs();
    @(negedge clk);
    rst = 1'b0;
    start_frame();
    wait_frame(d0 + 1);
    chk("mid_restart_nbytes", popped.size(), 4);
    chk("mid_restart_sof", popped_sof[0], 1'b1);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
